control_unit_mc: RTL and testbench

- Multi-cycle successor to the single-cycle combinational decoder.
- Decodes the 8-bit instruction opcode into registered datapath controls: ALU, immediate/sign muxes, register write, jump, and branch.
- Adds data-memory load/store sequencing against a BUSYWAIT handshake, with PC stall, a bounded-wait timeout, and illegal-opcode flagging.
- Sits between instruction fetch and the register file, ALU, and data memory.

---
 rtl/control_unit_mc.sv | 236 +++++++++++++++++++++++
 tb/tb_control_unit_mc.sv | 120 ++++++++++++
 2 files changed

// File: rtl/control_unit_mc.sv
// control_unit_mc
// Multi-cycle instruction decoder / sequencer. It decodes an opcode into
// registered datapath controls and sequences data-memory loads and stores
// against a BUSYWAIT handshake. While memory is busy it holds the PC, and it
// aborts a memory access that waits too long.
//
// Ports:
//   CLK, RESET         clock; synchronous active-high reset
//   OPCODE, INSTR_VALID instruction presented by fetch
//   BUSYWAIT           data memory busy
//   ALUOP, IMM, SIGN   ALU select and operand-2 mux controls (held until next accept)
//   WRITEENABLE,WB_SEL register-file write strobe and writeback source
//   J, BEQ, BNE        control-flow strobes
//   MEMREAD, MEMWRITE  data-memory requests
//   STALL              PC/fetch hold
//   ILLEGAL            one-cycle unknown-opcode pulse
//   MEM_ERR            sticky memory-timeout flag
module control_unit_mc #(
    parameter int OPCODE_WIDTH = 8,
    parameter int ALUOP_WIDTH  = 3,
    parameter int MEM_TIMEOUT  = 256
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic [OPCODE_WIDTH-1:0] OPCODE,
    input  logic                    INSTR_VALID,
    input  logic                    BUSYWAIT,
    output logic [ALUOP_WIDTH-1:0]  ALUOP,
    output logic                    IMM,
    output logic                    SIGN,
    output logic                    WRITEENABLE,
    output logic                    WB_SEL,
    output logic                    J,
    output logic                    BEQ,
    output logic                    BNE,
    output logic                    MEMREAD,
    output logic                    MEMWRITE,
    output logic                    STALL,
    output logic                    ILLEGAL,
    output logic                    MEM_ERR
);

    localparam logic [ALUOP_WIDTH-1:0] ALU_FWD  = ALUOP_WIDTH'(0);
    localparam logic [ALUOP_WIDTH-1:0] ALU_ADD  = ALUOP_WIDTH'(1);
    localparam logic [ALUOP_WIDTH-1:0] ALU_AND  = ALUOP_WIDTH'(2);
    localparam logic [ALUOP_WIDTH-1:0] ALU_OR   = ALUOP_WIDTH'(3);
    localparam logic [ALUOP_WIDTH-1:0] ALU_MULT = ALUOP_WIDTH'(4);
    localparam logic [ALUOP_WIDTH-1:0] ALU_SLL  = ALUOP_WIDTH'(5);
    localparam logic [ALUOP_WIDTH-1:0] ALU_SRL  = ALUOP_WIDTH'(6);

    // Counter is wide enough to hold MEM_TIMEOUT itself (saturation value).
    localparam int CNT_W = $clog2(MEM_TIMEOUT + 2);
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(MEM_TIMEOUT);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_EXEC      = 2'd1,
        ST_MEM_WAIT  = 2'd2,
        ST_WRITEBACK = 2'd3
    } state_t;

    typedef struct packed {
        logic [ALUOP_WIDTH-1:0] aluop;
        logic imm;
        logic sign;
        logic we;
        logic j;
        logic beq;
        logic bne;
        logic mrd;
        logic mwr;
        logic illegal;
    } dec_t;

    function automatic dec_t decode(input logic [OPCODE_WIDTH-1:0] op);
        dec_t d;
        d = '0;
        d.aluop = ALU_FWD;
        case (op)
            OPCODE_WIDTH'(0):  begin d.imm = 1'b1; d.we = 1'b1; end
            OPCODE_WIDTH'(1):  begin d.we = 1'b1; end
            OPCODE_WIDTH'(2):  begin d.aluop = ALU_ADD; d.we = 1'b1; end
            OPCODE_WIDTH'(3):  begin d.aluop = ALU_ADD; d.sign = 1'b1; d.we = 1'b1; end
            OPCODE_WIDTH'(4):  begin d.aluop = ALU_AND; d.we = 1'b1; end
            OPCODE_WIDTH'(5):  begin d.aluop = ALU_OR; d.we = 1'b1; end
            OPCODE_WIDTH'(6):  begin d.j = 1'b1; end
            OPCODE_WIDTH'(7):  begin d.aluop = ALU_ADD; d.sign = 1'b1; d.beq = 1'b1; end
            OPCODE_WIDTH'(8):  begin d.mrd = 1'b1; end
            OPCODE_WIDTH'(9):  begin d.imm = 1'b1; d.mrd = 1'b1; end
            OPCODE_WIDTH'(10): begin d.mwr = 1'b1; end
            OPCODE_WIDTH'(11): begin d.imm = 1'b1; d.mwr = 1'b1; end
            OPCODE_WIDTH'(12): begin d.aluop = ALU_ADD; d.sign = 1'b1; d.bne = 1'b1; end
            OPCODE_WIDTH'(13): begin d.aluop = ALU_MULT; d.we = 1'b1; end
            OPCODE_WIDTH'(14): begin d.aluop = ALU_SLL; d.imm = 1'b1; d.we = 1'b1; end
            OPCODE_WIDTH'(15): begin d.aluop = ALU_SRL; d.imm = 1'b1; d.we = 1'b1; end
            default:           begin d.illegal = 1'b1; end
        endcase
        return d;
    endfunction

    state_t                 state_r, state_s;
    logic [CNT_W-1:0]       cnt_r, cnt_s, cnt_inc_s;
    logic                   is_load_r, is_load_s;
    logic [ALUOP_WIDTH-1:0] aluop_s;
    logic imm_s, sign_s, we_s, wb_sel_s, j_s, beq_s, bne_s;
    logic mrd_s, mwr_s, stall_s, ill_s, mem_err_s;
    logic accept_s;
    dec_t dec_s;

    // Next-state and next-output decode; every output is registered below.
    always_comb begin
        dec_s     = decode(OPCODE);
        // An EXEC cycle holding a memory op always has a memory request up.
        accept_s  = INSTR_VALID &&
                    ((state_r == ST_IDLE) ||
                     ((state_r == ST_EXEC) && !MEMREAD && !MEMWRITE));
        cnt_inc_s = (cnt_r == TIMEOUT_C) ? cnt_r : cnt_r + CNT_W'(1);

        state_s   = state_r;
        cnt_s     = cnt_r;
        is_load_s = is_load_r;
        aluop_s   = ALUOP;
        imm_s     = IMM;
        sign_s    = SIGN;
        wb_sel_s  = WB_SEL;
        mem_err_s = MEM_ERR;
        we_s      = 1'b0;
        j_s       = 1'b0;
        beq_s     = 1'b0;
        bne_s     = 1'b0;
        mrd_s     = 1'b0;
        mwr_s     = 1'b0;
        stall_s   = 1'b0;
        ill_s     = 1'b0;

        case (state_r)
            ST_IDLE, ST_EXEC: begin
                if (accept_s) begin
                    if (dec_s.illegal) begin
                        ill_s   = 1'b1;
                        state_s = ST_IDLE;
                    end else begin
                        state_s   = ST_EXEC;
                        aluop_s   = dec_s.aluop;
                        imm_s     = dec_s.imm;
                        sign_s    = dec_s.sign;
                        wb_sel_s  = 1'b0;
                        we_s      = dec_s.we;
                        j_s       = dec_s.j;
                        beq_s     = dec_s.beq;
                        bne_s     = dec_s.bne;
                        mrd_s     = dec_s.mrd;
                        mwr_s     = dec_s.mwr;
                        stall_s   = dec_s.mrd | dec_s.mwr;
                        is_load_s = dec_s.mrd;
                    end
                end else if (state_r == ST_EXEC && (MEMREAD || MEMWRITE)) begin
                    state_s = ST_MEM_WAIT;
                    cnt_s   = '0;
                    mrd_s   = MEMREAD;
                    mwr_s   = MEMWRITE;
                    stall_s = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_MEM_WAIT: begin
                // Completion is checked first so it wins over a coincident timeout.
                if (!BUSYWAIT) begin
                    if (is_load_r) begin
                        state_s  = ST_WRITEBACK;
                        we_s     = 1'b1;
                        wb_sel_s = 1'b1;
                        stall_s  = 1'b1;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end else if ((MEM_TIMEOUT != 0) && (cnt_inc_s == TIMEOUT_C)) begin
                    state_s   = ST_IDLE;
                    mem_err_s = 1'b1;
                end else begin
                    cnt_s   = cnt_inc_s;
                    mrd_s   = MEMREAD;
                    mwr_s   = MEMWRITE;
                    stall_s = 1'b1;
                end
            end
            ST_WRITEBACK: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, counter and output registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_r     <= ST_IDLE;
            cnt_r       <= '0;
            is_load_r   <= 1'b0;
            ALUOP       <= ALU_FWD;
            IMM         <= 1'b0;
            SIGN        <= 1'b0;
            WRITEENABLE <= 1'b0;
            WB_SEL      <= 1'b0;
            J           <= 1'b0;
            BEQ         <= 1'b0;
            BNE         <= 1'b0;
            MEMREAD     <= 1'b0;
            MEMWRITE    <= 1'b0;
            STALL       <= 1'b0;
            ILLEGAL     <= 1'b0;
            MEM_ERR     <= 1'b0;
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            is_load_r   <= is_load_s;
            ALUOP       <= aluop_s;
            IMM         <= imm_s;
            SIGN        <= sign_s;
            WRITEENABLE <= we_s;
            WB_SEL      <= wb_sel_s;
            J           <= j_s;
            BEQ         <= beq_s;
            BNE         <= bne_s;
            MEMREAD     <= mrd_s;
            MEMWRITE    <= mwr_s;
            STALL       <= stall_s;
            ILLEGAL     <= ill_s;
            MEM_ERR     <= mem_err_s;
        end
    end

endmodule

// File: tb/tb_control_unit_mc.sv
// Directed bench for control_unit_mc (MEM_TIMEOUT=4). Each step drives the
// inputs for one cycle and pushes the output vector expected after the
// coming edge; the vector is popped and compared 1 time unit after that edge.
module tb_control_unit_mc;

    logic       CLK = 1'b0;
    logic       RESET;
    logic [7:0] OPCODE;
    logic       INSTR_VALID;
    logic       BUSYWAIT;
    logic [2:0] ALUOP;
    logic IMM, SIGN, WRITEENABLE, WB_SEL, J, BEQ, BNE;
    logic MEMREAD, MEMWRITE, STALL, ILLEGAL, MEM_ERR;

    int checks   = 0;
    int failures = 0;
    logic [14:0] exp_q[$];

    control_unit_mc #(.OPCODE_WIDTH(8), .ALUOP_WIDTH(3), .MEM_TIMEOUT(4)) dut (
        .CLK(CLK), .RESET(RESET), .OPCODE(OPCODE), .INSTR_VALID(INSTR_VALID),
        .BUSYWAIT(BUSYWAIT), .ALUOP(ALUOP), .IMM(IMM), .SIGN(SIGN),
        .WRITEENABLE(WRITEENABLE), .WB_SEL(WB_SEL), .J(J), .BEQ(BEQ), .BNE(BNE),
        .MEMREAD(MEMREAD), .MEMWRITE(MEMWRITE), .STALL(STALL),
        .ILLEGAL(ILLEGAL), .MEM_ERR(MEM_ERR)
    );

    always #5 CLK = ~CLK;

    // Vector layout: aluop[14:12] imm sign we wb_sel j beq bne mrd mwr stall ill mem_err
    function automatic logic [14:0] ev(input logic [2:0] aluop, input logic imm, input logic sign,
                                       input logic we, input logic wbs, input logic j,
                                       input logic beq, input logic bne, input logic mrd,
                                       input logic mwr, input logic stall, input logic ill,
                                       input logic merr);
        return {aluop, imm, sign, we, wbs, j, beq, bne, mrd, mwr, stall, ill, merr};
    endfunction

    task automatic step(input string tag, input logic rst, input logic v, input logic [7:0] op,
                        input logic busy, input logic [14:0] expv);
        logic [14:0] got;
        logic [14:0] want;
        RESET = rst; INSTR_VALID = v; OPCODE = op; BUSYWAIT = busy;
        exp_q.push_back(expv);
        @(posedge CLK);
        #1;
        got  = {ALUOP, IMM, SIGN, WRITEENABLE, WB_SEL, J, BEQ, BNE,
                MEMREAD, MEMWRITE, STALL, ILLEGAL, MEM_ERR};
        want = exp_q.pop_front();
        checks++;
        assert (got === want) else begin
            failures++;
            $error("FAIL %s got=%b exp=%b", tag, got, want);
        end
    endtask

    initial begin
        RESET = 1'b1; INSTR_VALID = 1'b0; OPCODE = 8'd0; BUSYWAIT = 1'b0;
        // Reset state
        step("reset0", 1'b1, 1'b0, 8'd0, 1'b0, ev(3'd0,0,0,0,0,0,0,0,0,0,0,0,0));
        step("reset1", 1'b1, 1'b0, 8'd0, 1'b0, ev(3'd0,0,0,0,0,0,0,0,0,0,0,0,0));
        // ADD single
        step("add_exec", 1'b0, 1'b1, 8'd2, 1'b0, ev(3'd1,0,0,1,0,0,0,0,0,0,0,0,0));
        step("add_idle", 1'b0, 1'b0, 8'd2, 1'b0, ev(3'd1,0,0,0,0,0,0,0,0,0,0,0,0));
        // SUB, AND, BNE back to back
        step("sub",      1'b0, 1'b1, 8'd3,  1'b0, ev(3'd1,0,1,1,0,0,0,0,0,0,0,0,0));
        step("and",      1'b0, 1'b1, 8'd4,  1'b0, ev(3'd2,0,0,1,0,0,0,0,0,0,0,0,0));
        step("bne",      1'b0, 1'b1, 8'd12, 1'b0, ev(3'd1,0,1,0,0,0,0,1,0,0,0,0,0));
        step("bne_idle", 1'b0, 1'b0, 8'd0,  1'b0, ev(3'd1,0,1,0,0,0,0,0,0,0,0,0,0));
        // Other decodes: LOADI, SLL, J, BEQ, MULT, SRL, OR, MOV
        step("loadi", 1'b0, 1'b1, 8'd0,  1'b0, ev(3'd0,1,0,1,0,0,0,0,0,0,0,0,0));
        step("sll",   1'b0, 1'b1, 8'd14, 1'b0, ev(3'd5,1,0,1,0,0,0,0,0,0,0,0,0));
        step("jump",  1'b0, 1'b1, 8'd6,  1'b0, ev(3'd0,0,0,0,0,1,0,0,0,0,0,0,0));
        step("beq",   1'b0, 1'b1, 8'd7,  1'b0, ev(3'd1,0,1,0,0,0,1,0,0,0,0,0,0));
        step("mult",  1'b0, 1'b1, 8'd13, 1'b0, ev(3'd4,0,0,1,0,0,0,0,0,0,0,0,0));
        step("srl",   1'b0, 1'b1, 8'd15, 1'b0, ev(3'd6,1,0,1,0,0,0,0,0,0,0,0,0));
        step("or",    1'b0, 1'b1, 8'd5,  1'b0, ev(3'd3,0,0,1,0,0,0,0,0,0,0,0,0));
        step("mov",   1'b0, 1'b1, 8'd1,  1'b0, ev(3'd0,0,0,1,0,0,0,0,0,0,0,0,0));
        step("idle0", 1'b0, 1'b0, 8'd0,  1'b0, ev(3'd0,0,0,0,0,0,0,0,0,0,0,0,0));
        // LWI, busy for 3 cycles after MEMREAD rises; INSTR_VALID during STALL ignored
        step("lwi_exec", 1'b0, 1'b1, 8'd9, 1'b1, ev(3'd0,1,0,0,0,0,0,0,1,0,1,0,0));
        step("lwi_w1",   1'b0, 1'b1, 8'd2, 1'b1, ev(3'd0,1,0,0,0,0,0,0,1,0,1,0,0));
        step("lwi_w2",   1'b0, 1'b1, 8'd2, 1'b1, ev(3'd0,1,0,0,0,0,0,0,1,0,1,0,0));
        step("lwi_w3",   1'b0, 1'b1, 8'd2, 1'b1, ev(3'd0,1,0,0,0,0,0,0,1,0,1,0,0));
        step("lwi_wb",   1'b0, 1'b1, 8'd2, 1'b0, ev(3'd0,1,0,1,1,0,0,0,0,0,1,0,0));
        step("lwi_idle", 1'b0, 1'b1, 8'd2, 1'b0, ev(3'd0,1,0,0,1,0,0,0,0,0,0,0,0));
        step("lwi_done", 1'b0, 1'b0, 8'd0, 1'b0, ev(3'd0,1,0,0,1,0,0,0,0,0,0,0,0));
        // SWD with BUSYWAIT stuck high: aborts after 4 MEM_WAIT cycles
        step("swd_exec", 1'b0, 1'b1, 8'd10, 1'b1, ev(3'd0,0,0,0,0,0,0,0,0,1,1,0,0));
        step("swd_w1",   1'b0, 1'b0, 8'd0,  1'b1, ev(3'd0,0,0,0,0,0,0,0,0,1,1,0,0));
        step("swd_w2",   1'b0, 1'b0, 8'd0,  1'b1, ev(3'd0,0,0,0,0,0,0,0,0,1,1,0,0));
        step("swd_w3",   1'b0, 1'b0, 8'd0,  1'b1, ev(3'd0,0,0,0,0,0,0,0,0,1,1,0,0));
        step("swd_w4",   1'b0, 1'b0, 8'd0,  1'b1, ev(3'd0,0,0,0,0,0,0,0,0,1,1,0,0));
        step("swd_tmo",  1'b0, 1'b0, 8'd0,  1'b1, ev(3'd0,0,0,0,0,0,0,0,0,0,0,0,1));
        step("merr_hold",1'b0, 1'b0, 8'd0,  1'b1, ev(3'd0,0,0,0,0,0,0,0,0,0,0,0,1));
        step("add_after",1'b0, 1'b1, 8'd2,  1'b1, ev(3'd1,0,0,1,0,0,0,0,0,0,0,0,1));
        step("and_pre",  1'b0, 1'b1, 8'd4,  1'b0, ev(3'd2,0,0,1,0,0,0,0,0,0,0,0,1));
        // Illegal opcode: pulse once, ALUOP holds AND
        step("illegal",  1'b0, 1'b1, 8'hFF, 1'b0, ev(3'd2,0,0,0,0,0,0,0,0,0,0,1,1));
        step("ill_off",  1'b0, 1'b0, 8'hFF, 1'b0, ev(3'd2,0,0,0,0,0,0,0,0,0,0,0,1));
        // Illegal opcode accepted from EXEC of a non-memory op
        step("mov2",     1'b0, 1'b1, 8'd1,  1'b0, ev(3'd0,0,0,1,0,0,0,0,0,0,0,0,1));
        step("ill_exec", 1'b0, 1'b1, 8'd16, 1'b0, ev(3'd0,0,0,0,0,0,0,0,0,0,0,1,1));
        // Reset during LWD MEM_WAIT
        step("lwd_exec", 1'b0, 1'b1, 8'd8, 1'b1, ev(3'd0,0,0,0,0,0,0,0,1,0,1,0,1));
        step("lwd_w1",   1'b0, 1'b0, 8'd0, 1'b1, ev(3'd0,0,0,0,0,0,0,0,1,0,1,0,1));
        step("lwd_rst",  1'b1, 1'b0, 8'd0, 1'b0, ev(3'd0,0,0,0,0,0,0,0,0,0,0,0,0));
        step("lwd_nowb", 1'b0, 1'b0, 8'd0, 1'b0, ev(3'd0,0,0,0,0,0,0,0,0,0,0,0,0));
        // Later LWD completes normally
        step("lwd2_exec",1'b0, 1'b1, 8'd8, 1'b1, ev(3'd0,0,0,0,0,0,0,0,1,0,1,0,0));
        step("lwd2_w1",  1'b0, 1'b0, 8'd0, 1'b0, ev(3'd0,0,0,0,0,0,0,0,1,0,1,0,0));
        step("lwd2_wb",  1'b0, 1'b0, 8'd0, 1'b0, ev(3'd0,0,0,1,1,0,0,0,0,0,1,0,0));
        step("lwd2_idle",1'b0, 1'b0, 8'd0, 1'b0, ev(3'd0,0,0,0,1,0,0,0,0,0,0,0,0));
        // New accept returns WB_SEL to 0
        step("wbsel_clr",1'b0, 1'b1, 8'd2, 1'b0, ev(3'd1,0,0,1,0,0,0,0,0,0,0,0,0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
